// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and the youngest-producer priority encoder.
package hazard_pkg;
  localparam int REG_AW_MAX = 8;
  localparam int MAX_STAGES = 7;
  localparam logic [2:0] FWD_NONE = 3'd0;
  typedef struct packed {
    logic v;
    logic wb;
    logic [REG_AW_MAX-1:0] dest;
    logic ld;
  } stage_entry_t;
  // bit k-1 of m is stage k; the lowest set bit is the youngest producer
  function automatic logic [2:0] youngest(input logic [MAX_STAGES-1:0] m);
    logic [2:0] s;
    s = FWD_NONE;
    for (int k = MAX_STAGES - 1; k >= 0; k--) s = m[k] ? 3'(k + 1) : s;
    return s;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one ID source against all in-flight entries.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int FWD_EN = 0
) (
  input  logic [REG_AW_MAX-1:0]         src,
  input  logic                          en,
  input  stage_entry_t [NUM_STAGES-1:0] ents,
  output logic [NUM_STAGES-1:0]         match,
  output logic                          ld_use,
  output logic [2:0]                    fwd_sel
);
  logic [MAX_STAGES-1:0] mv;
  always_comb begin
    mv = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      match[k] = en && ents[k].v && ents[k].wb && ents[k].dest == src;
      mv[k] = match[k];
    end
    ld_use = match[0] && ents[0].ld;
    fwd_sel = FWD_EN != 0 ? youngest(mv) : FWD_NONE;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writebacks beside ID, raises stalls,
// drives forwarding selects and counts stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int NUM_STAGES = 2,
  parameter int FWD_EN = 0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              two_src,
  input  logic              id_wb_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              freeze,
  output logic              hazard,
  output logic [2:0]        fwd_sel1,
  output logic [2:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);
  stage_entry_t [NUM_STAGES-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] m1, m2;
  logic lu1, lu2;
  hazard_match #(.NUM_STAGES(NUM_STAGES), .FWD_EN(FWD_EN)) u_m1 (
    .src(REG_AW_MAX'(src1)), .en(id_valid), .ents(stage_q),
    .match(m1), .ld_use(lu1), .fwd_sel(fwd_sel1)
  );
  hazard_match #(.NUM_STAGES(NUM_STAGES), .FWD_EN(FWD_EN)) u_m2 (
    .src(REG_AW_MAX'(src2)), .en(id_valid && two_src), .ents(stage_q),
    .match(m2), .ld_use(lu2), .fwd_sel(fwd_sel2)
  );
  assign hazard = FWD_EN != 0 ? (lu1 || lu2) : (|m1 || |m2);
  assign stall_cnt = cnt_q;
  always_comb begin
    stage_d = stage_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) stage_d[k] = stage_q[k-1];
      stage_d[0] = (hazard || flush || !id_valid) ? '0 :
                   '{v: 1'b1, wb: id_wb_en, dest: REG_AW_MAX'(id_dest), ld: id_mem_read};
      cnt_d = (hazard && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed + random stimulus on three parameterisations vs a pipeline model.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst, id_valid, two_src, id_wb_en, id_mem_read, flush, freeze;
  logic [3:0] src1, src2, id_dest;
  logic h0, h1, h2;
  logic [2:0] a1, a2, b1, b2, c1, c2;
  logic [15:0] cnt0, cnt1;
  logic [1:0] cnt2;

  hazard_scoreboard u0 (.clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
    .flush(flush), .freeze(freeze), .hazard(h0), .fwd_sel1(a1), .fwd_sel2(a2), .stall_cnt(cnt0));
  hazard_scoreboard #(.FWD_EN(1)) u1 (.clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1),
    .src2(src2), .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .flush(flush), .freeze(freeze), .hazard(h1), .fwd_sel1(b1),
    .fwd_sel2(b2), .stall_cnt(cnt1));
  hazard_scoreboard #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1),
    .src2(src2), .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_read(id_mem_read), .flush(flush), .freeze(freeze), .hazard(h2), .fwd_sel1(c1),
    .fwd_sel2(c2), .stall_cnt(cnt2));

  always #5 clk = ~clk;

  typedef struct {bit v; bit wb; bit ld; int dest;} ent_t;
  ent_t ma[2], mb[2];
  int ca, cb, cc;
  int compared = 0, mismatched = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input ent_t e, input int s);
    return e.v && e.wb && e.dest == s;
  endfunction

  // which pipeline stage (1 = youngest) produces register s, 0 if none
  function automatic int producer(input ent_t e0, input ent_t e1, input int s, input bit en);
    if (!en) return 0;
    if (hit(e0, s)) return 1;
    if (hit(e1, s)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ma[i] = '{0, 0, 0, 0};
      mb[i] = '{0, 0, 0, 0};
    end
    ca = 0; cb = 0; cc = 0;
  endtask

  task automatic cyc(input bit v, input int s1, input int s2, input bit two, input bit wb,
                     input int dst, input bit ld, input bit fl, input bit fz);
    int pa1, pa2, pb1, pb2;
    bit ha, hb;
    id_valid = v; src1 = 4'(s1); src2 = 4'(s2); two_src = two;
    id_wb_en = wb; id_dest = 4'(dst); id_mem_read = ld; flush = fl; freeze = fz;
    #1;
    pa1 = producer(ma[0], ma[1], s1, v);
    pa2 = producer(ma[0], ma[1], s2, v && two);
    pb1 = producer(mb[0], mb[1], s1, v);
    pb2 = producer(mb[0], mb[1], s2, v && two);
    ha = pa1 != 0 || pa2 != 0;
    hb = (pb1 == 1 || pb2 == 1) && mb[0].ld;
    chk("haz_nofwd", int'(h0), int'(ha));
    chk("sel1_nofwd", int'(a1), 0);
    chk("sel2_nofwd", int'(a2), 0);
    chk("cnt_nofwd", int'(cnt0), ca);
    chk("haz_fwd", int'(h1), int'(hb));
    chk("sel1_fwd", int'(b1), pb1);
    chk("sel2_fwd", int'(b2), pb2);
    chk("cnt_fwd", int'(cnt1), cb);
    chk("haz_cnt2", int'(h2), int'(ha));
    chk("cnt_sat", int'(cnt2), cc);
    if (!fz) begin
      if (ha) begin ca = ca < 65535 ? ca + 1 : ca; cc = cc < 3 ? cc + 1 : cc; end
      if (hb) cb = cb < 65535 ? cb + 1 : cb;
      ma[1] = ma[0];
      mb[1] = mb[0];
      ma[0] = (ha || fl || !v) ? '{0, 0, 0, 0} : '{1, wb, ld, dst};
      mb[0] = (hb || fl || !v) ? '{0, 0, 0, 0} : '{1, wb, ld, dst};
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; two_src = 0; id_wb_en = 0; id_mem_read = 0;
    flush = 0; freeze = 0; src1 = 0; src2 = 0; id_dest = 0;
    model_reset();
    #2;
    chk("rst_haz", int'(h0), 0);
    chk("rst_sel", int'(b1), 0);
    chk("rst_cnt", int'(cnt0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // producer of r4, then two dependent cycles stall, third does not
    cyc(1, 0, 0, 0, 1, 4, 0, 0, 0);
    cyc(1, 4, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4, 0, 0, 0, 0, 0, 0, 0);
    chk("tp_cnt2", int'(cnt0), 2);
    cyc(1, 4, 0, 0, 0, 0, 0, 0, 0);
    // src2 only matters when two_src
    cyc(1, 0, 0, 0, 1, 4, 0, 0, 0);
    cyc(1, 7, 4, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 4, 1, 0, 0, 0, 0, 0);
    // youngest producer wins; load at stage 1 stalls in forwarding mode
    cyc(1, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3, 1, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
    // freeze holds state while a hazard is pending
    cyc(1, 0, 0, 0, 1, 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 9, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 9, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 9, 0, 0, 0, 0, 0, 0, 0);
    // flushed producer leaves a bubble; flush held through freeze
    cyc(1, 0, 0, 0, 1, 5, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 5, 0, 1, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt2", int'(cnt2), 3);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    // async reset with a hazard pending must clear everything without a clock edge
    cyc(1, 0, 0, 0, 1, 6, 1, 0, 0);
    id_valid = 1; src1 = 4'd6; flush = 0; freeze = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_haz0", int'(h0), 0);
    chk("arst_haz1", int'(h1), 0);
    chk("arst_sel1", int'(b1), 0);
    chk("arst_cnt0", int'(cnt0), 0);
    chk("arst_cnt2", int'(cnt2), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 6, 0, 0, 1, 6, 0, 0, 0);
    cyc(1, 6, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
